// File: rtl/uart_pkg.sv
// Shared types and frame-geometry helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StRecover
    } rx_state_e;

    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser for the rx pin plus a 3-deep history used for majority-vote sampling.
module uart_rx_sampler #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rs_o,
    output logic vote_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;

    // Both chains reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            hist_q <= {hist_q[1:0], rs_o};
        end
    end

    assign rs_o   = sync_q[SYNC_STAGES-1];
    assign vote_o = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shifter and parity/framing/break reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
    localparam parity_e ParMode   = parity_e'(PARITY[1:0]);
    localparam bit      HasParity = (ParMode != PAR_NONE);
    localparam bit      OddParity = (ParMode == PAR_ODD);

    logic rs, vote;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk_i (clk),
        .rst_ni(reset),
        .rx_i  (rx),
        .rs_o  (rs),
        .vote_o(vote)
    );

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bits_q, bits_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_q, par_d, zero_q, zero_d, ferr_q, ferr_d;
    logic                 valid_q, valid_d, perr_q, perr_d, fe_q, fe_d, brk_q, brk_d;
    logic                 tick, stop_ferr, stop_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            zero_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            zero_q  <= zero_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
        end
    end

    assign tick      = (cnt_q == '0);
    assign stop_ferr = ferr_q | ~vote;
    // Break only looks at the first stop bit; later stop bits only feed frame_err.
    assign stop_zero = (bits_q == BitW'(STOP_BITS)) ? (zero_q & ~vote) : zero_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        zero_d  = zero_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        fe_d    = 1'b0;
        brk_d   = 1'b0;

        if (state_q inside {StStart, StData, StParity, StStop}) begin
            cnt_d = tick ? BitLoad : cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!rs) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                    bits_d  = BitW'(DATA_BITS);
                    par_d   = 1'b0;
                    zero_d  = 1'b1;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) state_d = vote ? StIdle : StData;
            end
            StData: begin
                if (tick) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ vote;
                    zero_d  = zero_q & ~vote;
                    bits_d  = bits_q - 1'b1;
                    if (bits_q == BitW'(1)) begin
                        state_d = HasParity ? StParity : StStop;
                        bits_d  = BitW'(STOP_BITS);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    par_d   = par_q ^ vote;
                    zero_d  = zero_q & ~vote;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    ferr_d = stop_ferr;
                    zero_d = stop_zero;
                    bits_d = bits_q - 1'b1;
                    if (bits_q == BitW'(1)) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = HasParity && (par_q != OddParity);
                        fe_d    = stop_ferr;
                        brk_d   = stop_ferr & stop_zero;
                        state_d = stop_ferr ? StRecover : StIdle;
                    end
                end
            end
            StRecover: begin
                // A line held low must return high before a new start bit is accepted.
                if (rs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = fe_q;
    assign break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: 8N1 receiver plus an even-parity, two-stop-bit receiver.
module tb_uart_rx_param;

    localparam int C = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic [7:0] d0, d1;
    logic v0, pe0, fe0, bk0, v1, pe1, fe1, bk1;

    always #5 clk = ~clk;

    uart_rx_param u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx0),
        .data      (d0),
        .data_valid(v0),
        .parity_err(pe0),
        .frame_err (fe0),
        .break_det (bk0)
    );

    uart_rx_param #(
        .CLKS_PER_BIT(8),
        .DATA_BITS   (8),
        .PARITY      (2),
        .STOP_BITS   (2),
        .SYNC_STAGES (2)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx1),
        .data      (d1),
        .data_valid(v1),
        .parity_err(pe1),
        .frame_err (fe1),
        .break_det (bk1)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n0 = 0, n1 = 0, stray = 0;
    int unsigned at0 = 0, at1 = 0;
    logic [7:0] rd0 = '0, rd1 = '0;
    logic rpe0 = 0, rfe0 = 0, rbk0 = 0, rpe1 = 0, rfe1 = 0, rbk1 = 0;

    always @(negedge clk) begin
        if (v0 === 1'b1) begin
            n0++; at0 = cyc; rd0 = d0; rpe0 = pe0; rfe0 = fe0; rbk0 = bk0;
        end else if ((pe0 | fe0 | bk0) !== 1'b0) stray++;
        if (v1 === 1'b1) begin
            n1++; at1 = cyc; rd1 = d1; rpe1 = pe1; rfe1 = fe1; rbk1 = bk1;
        end else if ((pe1 | fe1 | bk1) !== 1'b0) stray++;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) rx1 = v;
        else rx0 = v;
    endtask

    task automatic hold_bit(input bit which, input logic v, input int spike_at);
        for (int i = 0; i < C; i++) begin
            drive(which, (i == spike_at) ? 1'b0 : v);
            step(1);
        end
    endtask

    // which=0: 8N1 frame; which=1: 8E2 frame with explicit parity bit.
    task automatic send(input bit which, input logic [7:0] b, input logic par, input logic stop,
                        input int spike_bit);
        hold_bit(which, 1'b0, -1);
        for (int k = 0; k < 8; k++) hold_bit(which, b[k], (k == spike_bit) ? 2 : -1);
        if (which) begin
            hold_bit(which, par, -1);
            hold_bit(which, stop, -1);
        end
        hold_bit(which, stop, -1);
    endtask

    int unsigned m;

    initial begin
        reset = 1'b0;
        step(5);
        check("rst_data", 32'(d0), 32'h0);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_flags", 32'({pe0, fe0, bk0}), 32'h0);
        check("rst_valid1", 32'(v1), 32'h0);
        reset = 1'b1;

        // Test 1: 0xA5 with t0 = 100
        while (cyc < 98) step(1);
        send(0, 8'hA5, 1'b0, 1'b1, -1);
        step(4);
        check("t1_count", n0, 1);
        check("t1_cycle", at0, 177);
        check("t1_data", 32'(rd0), 32'hA5);
        check("t1_flags", 32'({rpe0, rfe0, rbk0}), 32'h0);

        // Test 2: even parity, wrong then right
        m = cyc;
        send(1, 8'h3C, 1'b1, 1'b1, -1);
        step(4);
        check("t2_count", n1, 1);
        check("t2_cycle", at1, m + 95);
        check("t2_data", 32'(rd1), 32'h3C);
        check("t2_perr", 32'(rpe1), 32'h1);
        check("t2_ferr", 32'(rfe1), 32'h0);
        send(1, 8'h3C, 1'b0, 1'b1, -1);
        step(4);
        check("t2b_count", n1, 2);
        check("t2b_perr", 32'(rpe1), 32'h0);

        // Test 3: 2-cycle glitch, then a real frame
        rx0 = 1'b0;
        step(2);
        rx0 = 1'b1;
        step(20);
        check("t3_glitch", n0, 1);
        send(0, 8'h5A, 1'b0, 1'b1, -1);
        step(4);
        check("t3_count", n0, 2);
        check("t3_data", 32'(rd0), 32'h5A);

        // Test 4: framing error, line held low, then recovery
        send(0, 8'h81, 1'b0, 1'b0, -1);
        step(40);
        check("t4_count", n0, 3);
        check("t4_data", 32'(rd0), 32'h81);
        check("t4_flags", 32'({rpe0, rfe0, rbk0}), 32'b010);
        rx0 = 1'b1;
        step(10);
        check("t4_norestart", n0, 3);
        send(0, 8'h42, 1'b0, 1'b1, -1);
        step(4);
        check("t4_count2", n0, 4);
        check("t4_data2", 32'(rd0), 32'h42);
        check("t4_flags2", 32'({rpe0, rfe0, rbk0}), 32'b000);

        // Test 5: break, line low for three frames
        rx0 = 1'b0;
        step(3 * 10 * C);
        rx0 = 1'b1;
        step(20);
        check("t5_count", n0, 5);
        check("t5_data", 32'(rd0), 32'h00);
        check("t5_flags", 32'({rpe0, rfe0, rbk0}), 32'b011);

        // Test 6: back-to-back frames, spike masked by vote, then reset mid-frame
        send(0, 8'h00, 1'b0, 1'b1, -1);
        check("t6_data0", 32'(rd0), 32'h00);
        check("t6_flags0", 32'({rpe0, rfe0, rbk0}), 32'b000);
        send(0, 8'hFF, 1'b0, 1'b1, 3);
        step(4);
        check("t6_count", n0, 7);
        check("t6_dataff", 32'(rd0), 32'hFF);
        hold_bit(0, 1'b0, -1);
        for (int k = 0; k < 4; k++) hold_bit(0, 1'b0, -1);
        rx0 = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("t6_rst_data", 32'(d0), 32'h0);
        check("t6_rst_out", 32'({v0, pe0, fe0, bk0}), 32'h0);
        step(6 * C);
        check("t6_nopulse", n0, 7);

        check("stray_flags", stray, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed-format simple UART receiver. Supports configurable data width, bit period, parity mode and stop-bit count. Adds an input synchroniser, majority-vote mid-bit sampling and start-bit glitch rejection. Reports parity, framing and break errors alongside each received word. Sits directly behind the rx pin and feeds byte-stream consumers via a one-cycle valid pulse.

Parameters:
CLKS_PER_BIT, 8, clk cycles per UART bit; legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first on the line.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; 1 or 2.
SYNC_STAGES, 2, synchroniser flops on rx; >= 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low reset.
rx  in  1  asynchronous serial input; idle high.
data  out  DATA_BITS  last received word; held until the next data_valid.
data_valid  out  1  one-cycle pulse when a frame completes.
parity_err  out  1  qualifies data_valid; parity mismatch (always 0 when PARITY=0).
frame_err  out  1  qualifies data_valid; a stop bit was sampled low.
break_det  out  1  qualifies data_valid; all data bits, parity bit and first stop bit were low.

Behaviour:
- Reset (reset=0 at a clk edge):
  - data=0; data_valid, parity_err, frame_err and break_det = 0.
  - Synchroniser flops and the vote shift register are set to 1.
  - FSM goes to IDLE and all counters clear.
  - Applies mid-frame too: the partial frame is discarded and no valid pulse is issued.
- rs = synchronised rx. A 3-bit shift register of rs is kept; the vote is the majority of its 3 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
- IDLE:
  - The first cycle with rs=0 is t0.
  - Go to START and load the bit counter.
- Sample timing: bit k (start = bit 0) is sampled by vote at cycle t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, using integer division.
- START:
  - Vote=1 at the sample point: glitch. Return to IDLE, no outputs.
  - Vote=0: go to DATA.
- DATA:
  - DATA_BITS samples, shifted in LSB first.
  - Then go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Sample one bit.
  - parity_err = (XOR of data bits and parity bit) != (PARITY==1 ? 1 : 0).
- STOP:
  - Sample STOP_BITS bits; any stop sample = 0 sets frame_err.
  - At the last stop sample, register data and the error flags, and pulse data_valid on the next cycle.
  - If all stop samples = 1, go straight to IDLE. This tolerates the next start edge arriving half a bit later.
  - If frame_err, go to RECOVER.
- RECOVER:
  - Wait until rs=1, then go to IDLE.
  - A held-low line is never re-interpreted as a new start bit.
- break_det=1 requires frame_err=1 and all sampled data, parity and first stop bits = 0.
- Error flags:
  - Valid only in the data_valid cycle; 0 at all other times.
  - data_valid still pulses when errors are set.
- Latency, pin-to-valid: rx edge to t0 is SYNC_STAGES cycles. data_valid is high at t0 + CLKS_PER_BIT/2 + (N-1)*CLKS_PER_BIT + 1, where N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT).
  - Bit counter width is clog2(DATA_BITS+1).
  - Neither wraps mid-bit; the cycle counter reloads at each sample point.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx_state_e enum (the six states above);
  - localparam functions for half-bit count and frame length N.
- One sub-module, uart_rx_sampler, contains:
  - the SYNC_STAGES synchroniser;
  - the 3-bit vote register.
- It outputs rs and vote; the FSM and datapath remain in uart_rx_param.

Test Plan:
1. Defaults (CLKS_PER_BIT=8, 8N1), send 0xA5 with t0 at cycle 100 -> data_valid high only at cycle 177, data=0xA5, all error flags 0.
2. PARITY=2, send 0x3C with parity bit 1 (wrong) -> data_valid pulse, data=0x3C, parity_err=1; resend with parity 0 -> parity_err=0.
3. rx low for 2 cycles then high -> no data_valid; then send 0x5A -> data=0x5A received correctly.
4. Send 0x81 with stop bit 0, then hold rx low 40 cycles -> frame_err=1, break_det=0, single data_valid; no further frame until rx returns high; then 0x42 is received cleanly.
5. Hold rx low for 3 full frames -> exactly one data_valid with data=0x00, frame_err=1, break_det=1.
6. Back-to-back 0x00, 0xFF with no idle gap, and a single 1-cycle rx spike inside a data bit (vote masks it) -> two pulses with correct data. Then assert reset during bit 4 of a third frame -> no pulse, outputs all 0 the cycle after reset.
